// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 host master running the mouse reset/enable handshake,
// then framing 3-byte movement packets and pulsing an interrupt per packet.
module mouse_master_sm #(
  parameter int unsigned STARTUP_CYCLES = 5000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic       BYTE_READ,
  input  logic [7:0] BYTE_RECEIVED,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE
);
  typedef enum logic [3:0] {
    S_STARTUP, S_SEND_FF, S_WAIT_FF_SENT, S_WAIT_FA1, S_WAIT_AA, S_WAIT_ID,
    S_SEND_F4, S_WAIT_F4_SENT, S_WAIT_FA2, S_READ_STATUS, S_READ_DX, S_READ_DY,
    S_INTERRUPT
  } state_t;
  localparam logic [31:0] L_START = 32'(STARTUP_CYCLES - 1);
  localparam logic [31:0] L_TMO = 32'(TIMEOUT_CYCLES - 1);
  state_t r_state, w_next;
  logic [31:0] r_timer;
  logic [7:0] r_byte, r_status, r_dx, r_ms, r_mx, r_my;
  logic r_init;
  logic w_ok, w_bad, w_tmo;
  assign w_ok = BYTE_READ && (BYTE_ERROR_CODE == 2'b00);
  assign w_bad = BYTE_READ && (BYTE_ERROR_CODE != 2'b00);
  assign w_tmo = r_timer == L_TMO;
  // Init waits: a received byte always decides (beating a same-cycle timeout);
  // anything but the expected byte forces a full restart.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_STARTUP:      w_next = (r_timer == L_START) ? S_SEND_FF : S_STARTUP;
      S_SEND_FF:      w_next = S_WAIT_FF_SENT;
      S_WAIT_FF_SENT: w_next = BYTE_SENT ? S_WAIT_FA1 : w_tmo ? S_STARTUP : r_state;
      S_WAIT_FA1:     w_next = BYTE_READ ? ((w_ok && BYTE_RECEIVED == 8'hFA) ? S_WAIT_AA : S_STARTUP) : w_tmo ? S_STARTUP : r_state;
      S_WAIT_AA:      w_next = BYTE_READ ? ((w_ok && BYTE_RECEIVED == 8'hAA) ? S_WAIT_ID : S_STARTUP) : w_tmo ? S_STARTUP : r_state;
      S_WAIT_ID:      w_next = BYTE_READ ? ((w_ok && BYTE_RECEIVED == 8'h00) ? S_SEND_F4 : S_STARTUP) : w_tmo ? S_STARTUP : r_state;
      S_SEND_F4:      w_next = S_WAIT_F4_SENT;
      S_WAIT_F4_SENT: w_next = BYTE_SENT ? S_WAIT_FA2 : w_tmo ? S_STARTUP : r_state;
      S_WAIT_FA2:     w_next = BYTE_READ ? ((w_ok && BYTE_RECEIVED == 8'hFA) ? S_READ_STATUS : S_STARTUP) : w_tmo ? S_STARTUP : r_state;
      S_READ_STATUS:  w_next = (w_ok && BYTE_RECEIVED[3]) ? S_READ_DX : S_READ_STATUS;
      S_READ_DX:      w_next = w_ok ? S_READ_DY : (w_bad || w_tmo) ? S_READ_STATUS : r_state;
      S_READ_DY:      w_next = w_ok ? S_INTERRUPT : (w_bad || w_tmo) ? S_READ_STATUS : r_state;
      S_INTERRUPT:    w_next = S_READ_STATUS;
      default:        w_next = S_STARTUP;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_STARTUP;
      r_timer <= '0;
      r_byte <= '0;
      r_init <= 1'b0;
      r_status <= '0;
      r_dx <= '0;
      r_ms <= '0;
      r_mx <= '0;
      r_my <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= (w_next != r_state) ? '0 : r_timer + 32'd1;
      r_byte <= (w_next == S_SEND_FF) ? 8'hFF : (w_next == S_SEND_F4) ? 8'hF4 : r_byte;
      r_init <= (w_next == S_STARTUP) ? 1'b0 : (r_state == S_WAIT_FA2 && w_next == S_READ_STATUS) ? 1'b1 : r_init;
      if (r_state == S_READ_STATUS && w_next == S_READ_DX) r_status <= BYTE_RECEIVED;
      if (r_state == S_READ_DX && w_next == S_READ_DY) r_dx <= BYTE_RECEIVED;
      // Published on entry to S_INTERRUPT so values are valid with the pulse
      if (r_state == S_READ_DY && w_next == S_INTERRUPT) begin
        r_ms <= r_status;
        r_mx <= r_dx;
        r_my <= BYTE_RECEIVED;
      end
    end
  end
  assign SEND_BYTE = (r_state == S_SEND_FF) || (r_state == S_SEND_F4);
  assign BYTE_TO_SEND = r_byte;
  assign READ_ENABLE = r_state inside {S_WAIT_FA1, S_WAIT_AA, S_WAIT_ID, S_WAIT_FA2, S_READ_STATUS, S_READ_DX, S_READ_DY};
  assign SEND_INTERRUPT = r_state == S_INTERRUPT;
  assign INIT_DONE = r_init;
  assign MOUSE_STATUS = r_ms;
  assign MOUSE_DX = r_mx;
  assign MOUSE_DY = r_my;
endmodule

// File: tb/tb_mouse_master_sm.sv
// tb_mouse_master_sm: init handshake, restart paths, packet framing and a
// randomized byte stream checked against a queue-based packet model.
module tb_mouse_master_sm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic send_byte, byte_sent = 1'b0, read_enable, byte_read = 1'b0;
  logic send_irq, init_done;
  logic [7:0] byte_to_send, byte_rx = '0, m_status, m_dx, m_dy;
  logic [1:0] err = '0;
  int n_checks = 0, n_fail = 0, n_sends = 0;
  logic [7:0] exp_s = '0, exp_x = '0, exp_y = '0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] b;
    logic [1:0] e;
    logic irq;
    logic [7:0] s, x, y;
  } vec_t;
  vec_t tbl[13];

  mouse_master_sm #(.STARTUP_CYCLES(10), .TIMEOUT_CYCLES(200)) dut (
    .CLK(clk), .RESET(rst_n), .SEND_BYTE(send_byte), .BYTE_TO_SEND(byte_to_send),
    .BYTE_SENT(byte_sent), .READ_ENABLE(read_enable), .BYTE_READ(byte_read),
    .BYTE_RECEIVED(byte_rx), .BYTE_ERROR_CODE(err), .MOUSE_STATUS(m_status),
    .MOUSE_DX(m_dx), .MOUSE_DY(m_dy), .SEND_INTERRUPT(send_irq), .INIT_DONE(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every clock edge passes through here, so SEND_BYTE spacing is watched throughout
  task automatic tick();
    logic prev;
    prev = send_byte;
    @(posedge clk);
    #1;
    if (send_byte) begin
      n_sends++;
      chk("send_not_back_to_back", {31'd0, prev}, 32'd0);
    end
  endtask

  task automatic pulse_read(input logic [7:0] b, input logic [1:0] e);
    byte_read = 1'b1;
    byte_rx = b;
    err = e;
    tick();
    byte_read = 1'b0;
    err = '0;
  endtask

  task automatic pulse_sent();
    byte_sent = 1'b1;
    tick();
    byte_sent = 1'b0;
  endtask

  task automatic wait_send(output int n);
    n = 0;
    while (!send_byte && n < 1000) begin
      tick();
      n++;
    end
    if (!send_byte) chk("send_wait_bound", 32'd0, 32'd1);
  endtask

  task automatic chk_outs(input string tag, input logic irq);
    chk({tag, "_irq"}, {31'd0, send_irq}, {31'd0, irq});
    chk({tag, "_status"}, {24'd0, m_status}, {24'd0, exp_s});
    chk({tag, "_dx"}, {24'd0, m_dx}, {24'd0, exp_x});
    chk({tag, "_dy"}, {24'd0, m_dy}, {24'd0, exp_y});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_send"}, {31'd0, send_byte}, 32'd0);
    chk({tag, "_tx_byte"}, {24'd0, byte_to_send}, 32'd0);
    chk({tag, "_read_en"}, {31'd0, read_enable}, 32'd0);
    chk({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    exp_s = '0; exp_x = '0; exp_y = '0;
    chk_outs(tag, 1'b0);
  endtask

  task automatic do_init();
    int n, s0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    s0 = n_sends;
    wait_send(n);
    chk("startup_delay", n, 10);
    chk("cmd_ff", {24'd0, byte_to_send}, 32'hFF);
    tick();
    chk("send_one_cycle", {31'd0, send_byte}, 32'd0);
    pulse_read(8'hFA, 2'b00);
    chk("read_en_in_sent_wait", {31'd0, read_enable}, 32'd0);
    pulse_sent();
    chk("read_en_fa1", {31'd0, read_enable}, 32'd1);
    pulse_read(8'hFA, 2'b00);
    pulse_read(8'hAA, 2'b00);
    pulse_read(8'h00, 2'b00);
    chk("cmd_f4_send", {31'd0, send_byte}, 32'd1);
    chk("cmd_f4", {24'd0, byte_to_send}, 32'hF4);
    tick();
    chk("tx_byte_hold", {24'd0, byte_to_send}, 32'hF4);
    pulse_sent();
    chk("init_done_before_fa", {31'd0, init_done}, 32'd0);
    pulse_read(8'hFA, 2'b00);
    chk("init_done", {31'd0, init_done}, 32'd1);
    chk("send_count", n_sends - s0, 2);
  endtask

  initial begin
    int n;
    tbl[0]  = '{8'h09, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{8'h05, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{8'hFB, 2'b00, 1'b1, 8'h09, 8'h05, 8'hFB};
    tbl[3]  = '{8'h01, 2'b00, 1'b0, 8'h09, 8'h05, 8'hFB};
    tbl[4]  = '{8'h08, 2'b00, 1'b0, 8'h09, 8'h05, 8'hFB};
    tbl[5]  = '{8'h10, 2'b00, 1'b0, 8'h09, 8'h05, 8'hFB};
    tbl[6]  = '{8'h33, 2'b01, 1'b0, 8'h09, 8'h05, 8'hFB};
    tbl[7]  = '{8'h08, 2'b00, 1'b0, 8'h09, 8'h05, 8'hFB};
    tbl[8]  = '{8'h01, 2'b00, 1'b0, 8'h09, 8'h05, 8'hFB};
    tbl[9]  = '{8'h02, 2'b00, 1'b1, 8'h08, 8'h01, 8'h02};
    tbl[10] = '{8'hAA, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02};
    tbl[11] = '{8'h7F, 2'b10, 1'b0, 8'h08, 8'h01, 8'h02};
    tbl[12] = '{8'h18, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02};

    // Wrong reply to 0xFF, then a withheld BYTE_SENT: both restart from the delay
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_send(n);
    tick();
    pulse_sent();
    pulse_read(8'hFC, 2'b00);
    chk("bad_resp_init_done", {31'd0, init_done}, 32'd0);
    chk("bad_resp_read_en", {31'd0, read_enable}, 32'd0);
    wait_send(n);
    chk("bad_resp_restart_delay", n, 10);
    chk("bad_resp_cmd_ff", {24'd0, byte_to_send}, 32'hFF);
    tick();
    wait_send(n);
    chk("timeout_restart_delay", n, 210);
    chk("timeout_cmd_ff", {24'd0, byte_to_send}, 32'hFF);
    chk("timeout_init_done", {31'd0, init_done}, 32'd0);

    do_init();
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("irq_one_cycle", {31'd0, send_irq}, 32'd0);
      pulse_read(tbl[i].b, tbl[i].e);
      exp_s = tbl[i].s; exp_x = tbl[i].x; exp_y = tbl[i].y;
      chk_outs("table", tbl[i].irq);
    end
    // Packet in flight is 0x18 so far; finish it
    pulse_read(8'h00, 2'b00);
    pulse_read(8'h00, 2'b00);
    exp_s = 8'h18; exp_x = 8'h00; exp_y = 8'h00;
    chk_outs("err_status_resync", 1'b1);

    // DX timeout drops the packet
    tick();
    pulse_read(8'h08, 2'b00);
    repeat (205) tick();
    pulse_read(8'h0C, 2'b00);
    pulse_read(8'h01, 2'b00);
    pulse_read(8'h02, 2'b00);
    exp_s = 8'h0C; exp_x = 8'h01; exp_y = 8'h02;
    chk_outs("dx_timeout_drop", 1'b1);

    // Byte arriving on the last timer cycle beats the timeout
    tick();
    pulse_read(8'h28, 2'b00);
    repeat (199) tick();
    pulse_read(8'h11, 2'b00);
    pulse_read(8'h22, 2'b00);
    exp_s = 8'h28; exp_x = 8'h11; exp_y = 8'h22;
    chk_outs("byte_beats_timeout", 1'b1);

    // Reset after the DX byte
    tick();
    pulse_read(8'h08, 2'b00);
    pulse_read(8'h05, 2'b00);
    rst_n = 1'b0;
    tick();
    chk_zero("mid_reset");
    rst_n = 1'b1;
    wait_send(n);
    chk("mid_reset_restart_delay", n, 10);
    chk("mid_reset_cmd_ff", {24'd0, byte_to_send}, 32'hFF);

    do_init();
    q.delete();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] v;
      logic [1:0] e;
      logic irq;
      repeat ($urandom_range(1, 4)) begin
        byte_sent = 1'($urandom_range(0, 1));
        tick();
        byte_sent = 1'b0;
      end
      v = 8'($urandom);
      e = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      irq = 1'b0;
      if (e != 2'b00) q.delete();
      else if (q.size() != 0 || v[3]) begin
        q.push_back(v);
        if (q.size() == 3) begin
          exp_s = q[0]; exp_x = q[1]; exp_y = q[2];
          irq = 1'b1;
          q.delete();
        end
      end
      pulse_read(v, e);
      chk_outs("random", irq);
      chk("random_init_done", {31'd0, init_done}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
